rr_arbiter4: RTL
================

# rr_arbiter4

Four-requester round-robin arbiter that shares a single downstream resource among requesters. Arbitration uses a rotated 4-bit priority encode whose starting point moves past the last winner. The grant is held until the owner signals completion. It sits in front of any shared datapath that needs one-hot grant plus an encoded owner index and valid flag.

## Interface
- TIMEOUT, default 16: maximum cycles a grant may be held. Used only when RR_ARB_TIMEOUT_EN is defined. Legal range 2..255.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  [3:0]  request vector; bit i high = requester i wants the resource
- done  input  1  single-cycle pulse from the current owner releasing the grant
- gnt  output  [3:0]  one-hot grant, registered
- gnt_id  output  [1:0]  encoded index of the granted requester, registered
- gnt_valid  output  1  high while any grant is held; equals |gnt
- timeout  output  1  single-cycle pulse on forced release; tied 0 without RR_ARB_TIMEOUT_EN

## Operation
- State machine with two states: IDLE and GRANT. Reset state is IDLE.
- Internal `last` [1:0] holds the index of the most recent winner. Reset value is 0.
- **Search order:** last-1, last-2, last-3, last, all modulo 4. After reset this gives 3, 2, 1, 0, which matches the fixed priority of highest index first.
- **IDLE:** if req != 0, the first set bit in search order wins.
  - gnt, gnt_id and gnt_valid load on that edge.
  - `last` is updated to the winner.
  - Next state is GRANT.
  - If req == 0, the block stays in IDLE with outputs at 0.
- **GRANT:** outputs hold. Release occurs at an edge where any of these is true:
  - done == 1, or
  - req[gnt_id] == 0 (owner withdrew), or
  - the timeout counter reached TIMEOUT-1 (timeout build only).
- On release: gnt = 0, gnt_id = 0, gnt_valid = 0, next state is IDLE.
- Changes on other req bits during GRANT are ignored. There is no preemption.
- done asserted while in IDLE is ignored.
- Simultaneous done and owner req drop count as a single release.

## Timing
- Reset values: gnt = 4'b0000, gnt_id = 2'd0, gnt_valid = 0, timeout = 0, last = 0, counter = 0, state = IDLE.
- Reset asserted mid-grant clears all outputs at the next edge, regardless of done or req.
- **Grant latency:** req is sampled high at edge k in IDLE, and gnt is visible after edge k, i.e. 1 cycle.
- **Release latency:** a release condition sampled at edge m means gnt is low after edge m.
- After every release there is exactly one IDLE cycle before the next grant. Minimum grant period is 2 cycles: 1 GRANT + 1 IDLE.
- gnt is always one-hot or zero; gnt_id always matches the set bit.
- The timeout counter is 8 bits. It clears on entry to GRANT and increments each GRANT cycle. Release happens after exactly TIMEOUT cycles of gnt high.

## Configuration
- Macro: RR_ARB_TIMEOUT_EN.
- **Defined:** the counter and the TIMEOUT limit are compiled in.
  - Forced release after TIMEOUT grant cycles.
  - timeout pulses high for one cycle, coincident with gnt going low.
  - A done pulse on the same edge as expiry takes priority, and timeout stays 0.
- **Undefined:** no counter; timeout is constant 0; a grant is held indefinitely until done or req withdrawal.

## Test plan
- **Reset priority:** after reset, req = 4'b1111. Expect gnt = 4'b1000, gnt_id = 3 one cycle later. Pulse done, then expect gnt = 0 for one cycle, then gnt = 4'b0100, gnt_id = 2.
- **Rotation:** req = 4'b1111 held, done pulsed every grant. Expect the grant sequence 3, 2, 1, 0, 3 with gnt_valid low for exactly one cycle between grants.
- **Sparse and wrap:** after reset, req = 4'b0001 then done. Expect grant 0, last = 0. Then req = 4'b1010. Expect gnt = 4'b1000 (search order 3, 2, 1, 0).
- **Withdrawal and no preemption:** grant 1 held; raise req[3] and keep it high. gnt stays 4'b0010. Drop req[1]. gnt goes 0 at that edge, then 4'b1000 after the IDLE cycle.
- **Reset mid-grant:** while gnt = 4'b0100, assert reset for one edge. All outputs are 0 after that edge. With req = 4'b0100 held after reset, gnt = 4'b0100 one cycle after reset deasserts.
- **Timeout (macro defined, TIMEOUT = 4):** req[2] held, no done. gnt = 4'b0100 for 4 cycles, timeout = 1 on the release edge, one IDLE cycle, then a re-grant to 2. Without the macro, gnt holds for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter; grant held until done or owner withdrawal.
// Optional forced release after TIMEOUT grant cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter4 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] r_gnt_id;
    logic [1:0] w_gnt_id_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic       w_win_vld;
    logic [1:0] w_win_id;
    logic       w_owner_req;
    logic       w_expire;
    logic       w_release;

    // Scan last-1 .. last-4; the lowest offset overwrites, so it wins.
    function automatic logic [2:0] pick(
        input logic [3:0] r,
        input logic [1:0] last
    );
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last - 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign {w_win_vld, w_win_id} = pick(req, r_last);

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Held at zero while idle, so it is zero on the first GRANT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (r_state == IDLE) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_expire = (r_state == GRANT) && (r_cnt == LP_LIMIT);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^8'(TIMEOUT);
    assign w_expire     = 1'b0;
`endif

    assign w_owner_req = req[r_gnt_id];
    assign w_release   = done | ~w_owner_req | w_expire;

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = 4'b0001 << w_win_id;
                    w_gnt_id_nxt = w_win_id;
                    w_last_nxt   = w_win_id;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = 4'b0000;
                    w_gnt_id_nxt  = 2'd0;
                    // Flag only releases caused solely by expiry.
                    w_timeout_nxt = w_expire & ~done & w_owner_req;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last    <= 2'd0;
            r_gnt     <= 4'b0000;
            r_gnt_id  <= 2'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = |r_gnt;

`ifdef RR_ARB_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    logic w_unused_to;
    assign w_unused_to = r_timeout;
    assign timeout     = 1'b0;
`endif

endmodule
